bcd_sub_serial: RTL and testbench

//   Digit-serial, multi-digit packed-BCD subtractor: diff = a - b, one BCD digit per clock, LSD first.

---
 rtl/bcd_sub_serial.sv | 188 ++++++++++++++++++
 tb/tb_bcd_sub_serial.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor (diff = a - b), one digit per clock, LSD first.
// Optional feature macro SIGN_MAG_EN: adds a ten's-complement pass so negative results come out as magnitude.
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  borrow,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  // Handshake: start is sampled only while busy=0; busy stays high from the
  // accepting edge through the single done cycle, and diff/borrow/invalid are
  // valid from the done cycle until the next done.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
`ifdef SIGN_MAG_EN
    S_NEG  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [W-1:0]    a_sr, b_sr, res_sr;
  logic [W-1:0]    diff_q;
  logic            borrow_q, invalid_q;
  logic            br;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            opnd_bad;

  logic [4:0]      sub_t;
  logic [3:0]      sub_d;
  logic            sub_br;
  logic [W-1:0]    sub_res;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    has_bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) has_bad_digit = 1'b1;
    end
  endfunction

  // New digit enters at the MSD end; everything else moves one digit toward LSD.
  function automatic logic [W-1:0] shift_in(input logic [3:0] d, input logic [W-1:0] r);
    logic [W+3:0] tmp;
    tmp      = {d, r};
    shift_in = tmp[W+3:4];
  endfunction

  function automatic logic [W-1:0] rot4(input logic [W-1:0] v);
    rot4 = (v >> 4) | (v << (W - 4));
  endfunction

  assign opnd_bad = has_bad_digit(a) | has_bad_digit(b);
  assign last     = (cnt == LAST);

  // One signed 5-bit digit step; a negative t is pulled back into 0..9 by +10.
  always_comb begin
    sub_t   = {1'b0, a_sr[3:0]} - {1'b0, b_sr[3:0]} - {4'd0, br};
    sub_br  = sub_t[4];
    sub_d   = sub_br ? (sub_t[3:0] + 4'd10) : sub_t[3:0];
    sub_res = shift_in(sub_d, res_sr);
  end

`ifdef SIGN_MAG_EN
  logic [4:0]      neg_t;
  logic [3:0]      neg_d;
  logic            neg_br;
  logic [W-1:0]    neg_res;

  always_comb begin
    neg_t   = 5'd0 - {1'b0, res_sr[3:0]} - {4'd0, br};
    neg_br  = neg_t[4];
    neg_d   = neg_br ? (neg_t[3:0] + 4'd10) : neg_t[3:0];
    neg_res = shift_in(neg_d, res_sr);
  end
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = opnd_bad ? S_DONE : S_SUB;
      S_SUB: begin
        if (last) begin
`ifdef SIGN_MAG_EN
          state_n = sub_br ? S_NEG : S_DONE;
`else
          state_n = S_DONE;
`endif
        end
      end
`ifdef SIGN_MAG_EN
      S_NEG:  if (last) state_n = S_DONE;
`endif
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            if (opnd_bad) begin
              diff_q    <= '0;
              borrow_q  <= 1'b0;
              invalid_q <= 1'b1;
            end
          end
        end
        S_SUB: begin
          a_sr   <= rot4(a_sr);
          b_sr   <= rot4(b_sr);
          res_sr <= sub_res;
          br     <= sub_br;
          cnt    <= last ? '0 : cnt + CW'(1);
          if (last) begin
`ifdef SIGN_MAG_EN
            if (sub_br) begin
              br <= 1'b0;  // negation pass starts with no borrow
            end else begin
              diff_q    <= sub_res;
              borrow_q  <= 1'b0;
              invalid_q <= 1'b0;
            end
`else
            diff_q    <= sub_res;
            borrow_q  <= sub_br;
            invalid_q <= 1'b0;
`endif
          end
        end
`ifdef SIGN_MAG_EN
        S_NEG: begin
          res_sr <= neg_res;
          br     <= neg_br;
          cnt    <= last ? '0 : cnt + CW'(1);
          if (last) begin
            diff_q    <= neg_res;
            borrow_q  <= 1'b1;  // only negative results reach this pass
            invalid_q <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign diff    = diff_q;
  assign borrow  = borrow_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Bench for bcd_sub_serial (DIGITS=4): directed cases, randomized operands, reset abort.
// Reference model works on decimal integers; follows SIGN_MAG_EN when defined.
module tb_bcd_sub_serial;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow, invalid;
  logic [W-1:0] diff;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  bcd_sub_serial #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit bad_bcd(input logic [W-1:0] v);
    bad_bcd = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad_bcd = 1'b1;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int n = 0;
    for (int i = DIGITS - 1; i >= 0; i--) n = n * 10 + int'(v[4*i +: 4]);
    return n;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  // Latency is counted in edges after the accepting edge until done is seen;
  // an invalid operand lands in DONE on the accepting edge itself.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       output logic [W-1:0] ed, output bit eb, output bit ei, output int el);
    int d, pow10;
    pow10 = 1;
    for (int i = 0; i < DIGITS; i++) pow10 *= 10;
    if (bad_bcd(ta) || bad_bcd(tb_v)) begin
      ed = '0; eb = 1'b0; ei = 1'b1; el = 0;
    end else begin
      d  = bcd2int(ta) - bcd2int(tb_v);
      eb = (d < 0);
      ei = 1'b0;
      el = DIGITS;
`ifdef SIGN_MAG_EN
      if (d < 0) begin
        ed = int2bcd(-d);
        el = 2 * DIGITS;
      end else ed = int2bcd(d);
`else
      ed = int2bcd(d < 0 ? pow10 + d : d);
`endif
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit poke);
    logic [W-1:0] ed, qd;
    bit eb, ei;
    int el, n;
    model(ta, tb_v, ed, eb, ei, el);
    exp_q.push_back(ed);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      if (poke && n == 1) begin
        start = 1'b1; a = 16'h9999; b = 16'h0000;
      end else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    qd = exp_q.pop_front();
    check("latency", n, el);
    check("busy_in_done", 32'(busy), 32'd1);
    check("diff", 32'(diff), 32'(qd));
    check("borrow", 32'(borrow), 32'(eb));
    check("invalid", 32'(invalid), 32'(ei));
    if (poke) begin
      start = 1'b1; a = 16'h9999; b = 16'h0000;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_release", 32'(busy), 32'd0);
    check("diff_held", 32'(diff), 32'(qd));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit seen_done;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_invalid", 32'(invalid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h1234, 16'h0567, 1'b0);
    do_op(16'h0100, 16'h0001, 1'b0);
    do_op(16'h0005, 16'h0010, 1'b0);
    do_op(16'h12A4, 16'h0001, 1'b0);
    do_op(16'h1234, 16'h0567, 1'b1);  // start re-pulsed while busy, incl. the done cycle
    do_op(16'h0000, 16'h0000, 1'b0);
    do_op(16'h4321, 16'h4321, 1'b0);
    do_op(16'h9999, 16'h0000, 1'b0);
    do_op(16'h0000, 16'h9999, 1'b0);
    do_op(16'h0001, 16'hF000, 1'b1);

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      do_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    do_op(16'h5000, 16'h0001, 1'b0);  // leaves a nonzero diff before the abort
    @(negedge clk);
    a = 16'h9999; b = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow), 32'd0);
    check("abort_invalid", 32'(invalid), 32'd0);
    seen_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    do_op(16'h9999, 16'h1111, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
